load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the core's memory stage and the word-addressed data memory (1024 x 32, combinational read, word write on clk rising edge when WE is high).
- Converts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses.
- Sign- or zero-extends load data.
- Performs read-modify-write for sub-word stores.
- Flags misaligned, illegal or out-of-range accesses.
- Uses a valid/ready handshake so the core stalls while the unit is busy.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the data memory; byte addresses >= 4*MEM_WORDS are access faults.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  unit can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (width/sign)
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low bytes used for SB/SH
- resp_valid  out  1  one-cycle pulse: request complete
- resp_err  out  1  valid with resp_valid: misaligned/illegal/out-of-range
- resp_rdata  out  32  extended load data; 0 for stores and errors
- mem_A  out  32  word-aligned byte address to the data memory
- mem_WD  out  32  write data to the data memory
- mem_WE  out  1  write enable to the data memory
- mem_RD  in  32  combinational read data from the data memory

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all registered outputs 0 (resp_valid, resp_err, resp_rdata, mem_A, mem_WD, mem_WE). req_ready = 1 only when reset is released and the state is IDLE.
- Reset mid-operation: abort the operation. mem_WE drops immediately, no write occurs, no response is issued.
- States: IDLE, LOAD, ST_RD, ST_WR, ERR.
- IDLE:
  - req_ready = 1. On req_valid at an edge, latch we/funct3/addr/wdata.
  - mem_A <= {addr[31:2],2'b00}.
  - Decode and go to the next state:
    - error -> ERR
    - load -> LOAD
    - SW -> ST_WR, with mem_WD <= wdata
    - SB/SH -> ST_RD
- Error conditions:
  - Load funct3 in {3,6,7} or store funct3 >= 3.
  - Halfword with addr[0] = 1; word with addr[1:0] != 0.
  - addr >= 4*MEM_WORDS.
- LOAD (1 cycle):
  - Capture mem_RD and select the byte lane addr[1:0] or halfword lane addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Register the result to resp_rdata. resp_valid <= 1. Go to IDLE.
- ST_RD (1 cycle):
  - Capture mem_RD.
  - Merge wdata[7:0] into byte lane addr[1:0] (SB) or wdata[15:0] into halfword lane addr[1] (SH).
  - mem_WD <= merged word. Go to ST_WR.
- ST_WR (1 cycle): mem_WE = 1 for exactly this cycle; the memory writes at the closing edge. resp_valid <= 1, resp_rdata <= 0. Go to IDLE.
- ERR (1 cycle): no memory access (mem_WE stays 0). resp_valid <= 1, resp_err <= 1, resp_rdata <= 0. Go to IDLE.
- resp_valid and resp_err are one-cycle pulses. resp_rdata holds its value until the next response.
- Latency, counted from the accept edge N; resp_valid is high in the cycle after the edge listed:
  - load: N+2
  - SW: N+2
  - SB/SH: N+3
  - error: N+2
- req_ready is 0 in all non-IDLE states and is high again in the cycle resp_valid is high, so back-to-back requests are accepted with no bubble beyond the stated latency.
- mem_WE is asserted only in ST_WR and never in the same cycle as an ST_RD capture.
- Request inputs are ignored while busy; the latched copy is used throughout the operation.

Test Plan:
- Reset mid-SB: assert rst low during ST_RD -> mem_WE never high; no resp_valid; memory word unchanged; req_ready = 1 one cycle after release.
- SW then LW: SW addr 0x10, data 0xDEADBEEF -> mem_WE pulses once (resp at N+2); LW 0x10 -> resp_rdata 0xDEADBEEF, resp_err 0.
- SB lane merge: with word 0x10 = 0xDEADBEEF, SB addr 0x12 data 0x000000AA -> word becomes 0xDEAABEEF, resp at N+3. Then LB 0x12 -> 0xFFFFFFAA; LBU 0x12 -> 0x000000AA.
- SH/LH: SH addr 0x16 data 0x8001 -> upper half of word 0x14 = 0x8001. LH 0x16 -> 0xFFFF8001; LHU -> 0x00008001.
- Errors: LW 0x11, SH 0x13, load funct3 = 3, SW 0x1000 (MEM_WORDS = 1024) -> each gives resp_err = 1, resp_rdata 0, no mem_WE, resp at N+2.
- Back-to-back: LW immediately after SW with req_valid held high -> second request accepted in the cycle the first resp_valid is high; total 4 cycles for both.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store to word-memory bridge with sub-word
// extraction, read-modify-write stores and fault detection.
module load_store_unit #(
   parameter int MEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [31:0] mem_A,
   output logic [31:0] mem_WD,
   output logic        mem_WE,
   input  logic [31:0] mem_RD
);
   typedef enum logic [2:0] {IDLE, LOAD, ST_RD, ST_WR, ERR} state_t;
   localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);
   state_t      r_state;
   logic [2:0]  r_funct3;
   logic [1:0]  r_lane;
   logic [31:0] r_wdata;
   logic        w_bad_f3, w_misalign, w_oob, w_err;
   logic [4:0]  w_sh;
   logic [31:0] w_shifted, w_ld, w_mask, w_merged;
   assign req_ready  = rst && (r_state == IDLE);
   assign w_bad_f3   = req_we ? (req_funct3 >= 3'd3)
                              : (req_funct3 == 3'd3 || req_funct3 >= 3'd6);
   assign w_misalign = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                       (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
   assign w_oob      = req_addr >= ADDR_LIMIT;
   assign w_err      = w_bad_f3 || w_misalign || w_oob;
   // Byte offset within the word drives both lane extraction and merge
   assign w_sh      = {r_lane, 3'b000};
   assign w_shifted = mem_RD >> w_sh;
   assign w_ld      = r_funct3 == 3'd0 ? {{24{w_shifted[7]}}, w_shifted[7:0]} :
                      r_funct3 == 3'd1 ? {{16{w_shifted[15]}}, w_shifted[15:0]} :
                      r_funct3 == 3'd4 ? {24'd0, w_shifted[7:0]} :
                      r_funct3 == 3'd5 ? {16'd0, w_shifted[15:0]} : mem_RD;
   assign w_mask    = (r_funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << w_sh;
   assign w_merged  = (mem_RD & ~w_mask) | ((r_wdata << w_sh) & w_mask);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_funct3   <= 3'd0;
         r_lane     <= 2'd0;
         r_wdata    <= 32'd0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'd0;
         mem_A      <= 32'd0;
         mem_WD     <= 32'd0;
         mem_WE     <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         mem_WE     <= 1'b0;
         case (r_state)
            IDLE: if (req_valid) begin
               r_funct3 <= req_funct3;
               r_lane   <= req_addr[1:0];
               r_wdata  <= req_wdata;
               mem_A    <= {req_addr[31:2], 2'b00};
               if (w_err) r_state <= ERR;
               else if (!req_we) r_state <= LOAD;
               else if (req_funct3 == 3'd2) begin
                  r_state <= ST_WR;
                  mem_WD  <= req_wdata;
                  mem_WE  <= 1'b1;
               end else r_state <= ST_RD;
            end
            LOAD: begin
               resp_valid <= 1'b1;
               resp_rdata <= w_ld;
               r_state    <= IDLE;
            end
            ST_RD: begin
               mem_WD  <= w_merged;
               mem_WE  <= 1'b1;
               r_state <= ST_WR;
            end
            ST_WR: begin
               resp_valid <= 1'b1;
               resp_rdata <= 32'd0;
               r_state    <= IDLE;
            end
            ERR: begin
               resp_valid <= 1'b1;
               resp_err   <= 1'b1;
               resp_rdata <= 32'd0;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit against a bench-side
// 1024-word memory with hand-computed expected results.
module tb_load_store_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid, resp_err, mem_WE;
   logic [31:0] resp_rdata, mem_A, mem_WD, mem_RD;
   logic [31:0] mem [0:1023];
   int          n_checks = 0;
   int          n_errors = 0;

   load_store_unit #(.MEM_WORDS(1024)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
      .resp_rdata(resp_rdata), .mem_A(mem_A), .mem_WD(mem_WD),
      .mem_WE(mem_WE), .mem_RD(mem_RD)
   );

   always #5 clk = ~clk;
   assign mem_RD = mem[mem_A[11:2]];
   always @(posedge clk) if (mem_WE) mem[mem_A[11:2]] <= mem_WD;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input logic exp_err, input logic [31:0] exp_rd);
      int n = 0;
      int wes = 0;
      @(negedge clk);
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      check({tag, ".rdy"}, 32'(req_ready), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      do begin
         @(negedge clk);
         n++;
         wes += int'(mem_WE);
      end while (!resp_valid && n < 8);
      check({tag, ".lat"}, 32'(n), 32'(exp_lat));
      check({tag, ".err"}, 32'(resp_err), 32'(exp_err));
      check({tag, ".rd"}, resp_rdata, exp_rd);
      check({tag, ".we"}, 32'(wes), (we && !exp_err) ? 32'd1 : 32'd0);
      @(negedge clk);
      check({tag, ".pulse"}, {30'd0, resp_valid, resp_err}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      #12;
      check("rst.ready", 32'(req_ready), 32'd0);
      check("rst.outs", {29'd0, resp_valid, resp_err, mem_WE}, 32'd0);
      check("rst.rdata", resp_rdata, 32'd0);
      check("rst.memA", mem_A, 32'd0);
      @(negedge clk); rst = 1'b1;
      #1 check("rel.ready", 32'(req_ready), 32'd1);

      do_req("sw10",  1, 3'd2, 32'h10, 32'hDEADBEEF, 2, 0, 32'h0);
      check("mem4.sw", mem[4], 32'hDEADBEEF);
      do_req("lw10",  0, 3'd2, 32'h10, 32'h0, 2, 0, 32'hDEADBEEF);
      do_req("sb12",  1, 3'd0, 32'h12, 32'h000000AA, 3, 0, 32'h0);
      check("mem4.sb", mem[4], 32'hDEAABEEF);
      do_req("lb12",  0, 3'd0, 32'h12, 32'h0, 2, 0, 32'hFFFFFFAA);
      do_req("lbu12", 0, 3'd4, 32'h12, 32'h0, 2, 0, 32'h000000AA);
      do_req("lb13",  0, 3'd0, 32'h13, 32'h0, 2, 0, 32'hFFFFFFDE);
      do_req("lh10",  0, 3'd1, 32'h10, 32'h0, 2, 0, 32'hFFFFBEEF);
      do_req("sh16",  1, 3'd1, 32'h16, 32'h00008001, 3, 0, 32'h0);
      check("mem5.sh", mem[5], 32'h80010000);
      do_req("lh16",  0, 3'd1, 32'h16, 32'h0, 2, 0, 32'hFFFF8001);
      do_req("lhu16", 0, 3'd5, 32'h16, 32'h0, 2, 0, 32'h00008001);

      do_req("e.lw11",  0, 3'd2, 32'h11, 32'h0, 2, 1, 32'h0);
      do_req("lbu13",   0, 3'd4, 32'h13, 32'h0, 2, 0, 32'h000000DE);
      do_req("e.sh13",  1, 3'd1, 32'h13, 32'h1234, 2, 1, 32'h0);
      do_req("lw10b",   0, 3'd2, 32'h10, 32'h0, 2, 0, 32'hDEAABEEF);
      do_req("e.f3",    0, 3'd3, 32'h10, 32'h0, 2, 1, 32'h0);
      do_req("e.sw1000", 1, 3'd2, 32'h1000, 32'hCAFEF00D, 2, 1, 32'h0);
      check("mem0.noerrw", mem[0], 32'h0);
      do_req("e.sf3",   1, 3'd3, 32'h20, 32'h5, 2, 1, 32'h0);
      do_req("lw_last", 0, 3'd2, 32'hFFC, 32'h0, 2, 0, 32'h0);

      // Back-to-back: LW queued behind SW with req_valid held high
      @(negedge clk);
      req_we = 1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h12345678; req_valid = 1;
      @(posedge clk);
      @(negedge clk);
      check("b2b.c1", {30'd0, resp_valid, req_ready}, 32'd0);
      req_we = 0; req_addr = 32'h20; req_wdata = 32'h0;
      @(negedge clk);
      check("b2b.c2", {30'd0, resp_valid, req_ready}, 32'd3);
      @(posedge clk);
      #1 req_valid = 0;
      @(negedge clk);
      check("b2b.c3", 32'(resp_valid), 32'd0);
      @(negedge clk);
      check("b2b.c4", 32'(resp_valid), 32'd1);
      check("b2b.rd", resp_rdata, 32'h12345678);

      // Reset while the SB is in its read phase
      @(negedge clk);
      req_we = 1; req_funct3 = 3'd0; req_addr = 32'h18; req_wdata = 32'h55; req_valid = 1;
      @(posedge clk);
      #1 req_valid = 0;
      @(negedge clk);
      check("mid.we0", 32'(mem_WE), 32'd0);
      rst = 1'b0;
      #1 check("mid.rst", {29'd0, mem_WE, resp_valid, req_ready}, 32'd0);
      begin
         int seen = 0;
         for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            seen += int'(mem_WE) + int'(resp_valid);
         end
         rst = 1'b1;
         @(negedge clk);
         check("mid.ready", 32'(req_ready), 32'd1);
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen += int'(mem_WE) + int'(resp_valid);
         end
         check("mid.quiet", 32'(seen), 32'd0);
      end
      check("mid.mem6", mem[6], 32'h0);
      do_req("lw18", 0, 3'd2, 32'h18, 32'h0, 2, 0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
